// File: rtl/uart_rx_fsm.sv
// Frame-level sequencer for the UART receiver: detects the start bit, runs the
// bit/edge counter and fires mid-bit strobes to the datapath checkers.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] prescale,
    input  logic [3:0] bit_cnt,
    input  logic [5:0] edge_cnt,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       cnt_enable,
    output logic       cnt_clr,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       deser_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       par_error,
    output logic       frm_error
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_e;

    localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

    state_e     state_q, state_d;
    logic       par_q, par_d;
    logic       stp_q, stp_d;
    logic [5:0] chk_edge;
    logic       at_chk;
    logic       bit_end;

    // Sample two edges past the nominal middle so the 3-tap sampler window is centred.
    assign chk_edge = {1'b0, prescale[5:1]} + 6'd2;
    assign at_chk   = (edge_cnt == chk_edge);
    assign bit_end  = (edge_cnt == (prescale - 6'd1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of all others, independent of block ordering.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            par_q   <= 1'b0;
            stp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            par_q   <= par_d;
            stp_q   <= stp_d;
        end
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d     = state_q;
        par_d       = par_q;
        stp_d       = stp_q;
        cnt_enable  = 1'b0;
        cnt_clr     = 1'b0;
        strt_chk_en = 1'b0;
        deser_en    = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        data_valid  = 1'b0;
        par_error   = 1'b0;
        frm_error   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!RX_IN) begin
                    state_d = START;
                    par_d   = 1'b0;
                    stp_d   = 1'b0;
                end
            end
            START: begin
                cnt_enable  = 1'b1;
                strt_chk_en = at_chk;
                if (at_chk && strt_glitch) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_enable = 1'b1;
                deser_en   = at_chk;
                if (bit_end && (bit_cnt == LAST_DATA_BIT)) begin
                    state_d = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                cnt_enable = 1'b1;
                par_chk_en = at_chk;
                if (at_chk) begin
                    par_d = par_err;
                end
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                cnt_enable = 1'b1;
                stp_chk_en = at_chk;
                // Leave at mid stop bit so a following start edge is never missed.
                if (at_chk) begin
                    stp_d   = stp_err;
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_clr    = 1'b1;
                data_valid = !par_q && !stp_q;
                par_error  = par_q;
                frm_error  = stp_q;
                if (!RX_IN) begin
                    state_d = START;
                    par_d   = 1'b0;
                    stp_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        dat_samp_en = cnt_enable;
    end

endmodule
